multi_window_counter: RTL and testbench

Parametrised successor to the single-trigger timing counter used in the display sync path. It is a free-running modulo counter. Its terminal value is programmable at run time and updates glitch-free at wrap. It provides N independent compare windows, each with wrap-around support, and a carry output for cascading. One instance drives a horizontal or vertical timing axis, producing the sync, blanking and active-video windows directly, so no external compare logic is needed. Two instances cascade through CARRY_OUT into ENABLE to form a full frame timer.

---
 rtl/multi_window_counter.sv | 82 ++++++++
 tb/tb_multi_window_counter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_window_counter.sv
// multi_window_counter: free-running modulo counter with run-time terminal value,
// N wrap-aware compare windows and a cascade carry.
`default_nettype none

module multi_window_counter #(
    parameter int          WIDTH      = 10,
    parameter int          CHANNELS   = 2,
    parameter int unsigned INIT_MAX   = 799,
    parameter int unsigned INIT_COUNT = INIT_MAX
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      ENABLE,
    input  logic                      CLEAR,
    input  logic [WIDTH-1:0]          MAX_VALUE,
    input  logic [CHANNELS*WIDTH-1:0] CMP_START,
    input  logic [CHANNELS*WIDTH-1:0] CMP_END,
    output logic [WIDTH-1:0]          COUNT,
    output logic                      TERMINAL,
    output logic                      CARRY_OUT,
    output logic [CHANNELS-1:0]       WINDOW
);

    localparam logic [WIDTH-1:0] INIT_MAX_W   = WIDTH'(INIT_MAX);
    localparam logic [WIDTH-1:0] INIT_COUNT_W = WIDTH'(INIT_COUNT);

    logic [WIDTH-1:0]    count_q, count_d;
    logic [WIDTH-1:0]    max_q, max_d;
    logic                term_q, term_d;
    logic [CHANNELS-1:0] win_q, win_d;

    // The terminal value only reloads at a period boundary, so a mid-period
    // MAX_VALUE change never shortens or stretches the running period.
    always_comb begin
        count_d = count_q;
        max_d   = max_q;
        if (CLEAR) begin
            count_d = '0;
            max_d   = MAX_VALUE;
        end else if (ENABLE) begin
            if (count_q == max_q) begin
                count_d = '0;
                max_d   = MAX_VALUE;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
        term_d = (count_d == max_d);
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_win
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] e;
        assign s = CMP_START[c*WIDTH +: WIDTH];
        assign e = CMP_END[c*WIDTH +: WIDTH];
        // start > end describes a window that wraps through zero
        assign win_d[c] = (s <= e) ? ((count_d >= s) && (count_d <= e))
                                   : ((count_d >= s) || (count_d <= e));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q <= INIT_COUNT_W;
            max_q   <= INIT_MAX_W;
            term_q  <= (INIT_COUNT_W == INIT_MAX_W);
            win_q   <= '0;
        end else begin
            count_q <= count_d;
            max_q   <= max_d;
            term_q  <= term_d;
            win_q   <= win_d;
        end
    end

    assign COUNT     = count_q;
    assign TERMINAL  = term_q;
    assign WINDOW    = win_q;
    assign CARRY_OUT = term_q & ENABLE & ~CLEAR;

endmodule

`default_nettype wire

// File: tb/tb_multi_window_counter.sv
// Directed bench for multi_window_counter: a behavioural model pushes expected
// outputs to a scoreboard queue; results are popped and checked after each edge.
`default_nettype none

module tb_multi_window_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, clr;
    logic [9:0]  maxv;
    logic [19:0] cs, ce;
    logic [9:0]  count;
    logic        term, carry;
    logic [1:0]  win;

    logic        en_a, clr_c;
    logic [3:0]  cnt_a, cnt_b;
    logic        term_a, term_b, carry_a, carry_b;
    logic        win_a, win_b;

    multi_window_counter u_dut (
        .CLK(clk), .RST_N(rst_n), .ENABLE(en), .CLEAR(clr), .MAX_VALUE(maxv),
        .CMP_START(cs), .CMP_END(ce), .COUNT(count), .TERMINAL(term),
        .CARRY_OUT(carry), .WINDOW(win)
    );

    multi_window_counter #(.WIDTH(4), .CHANNELS(1), .INIT_MAX(3)) u_up (
        .CLK(clk), .RST_N(rst_n), .ENABLE(en_a), .CLEAR(clr_c), .MAX_VALUE(4'd3),
        .CMP_START(4'd0), .CMP_END(4'd0), .COUNT(cnt_a), .TERMINAL(term_a),
        .CARRY_OUT(carry_a), .WINDOW(win_a)
    );

    multi_window_counter #(.WIDTH(4), .CHANNELS(1), .INIT_MAX(2)) u_down (
        .CLK(clk), .RST_N(rst_n), .ENABLE(carry_a), .CLEAR(clr_c), .MAX_VALUE(4'd2),
        .CMP_START(4'd0), .CMP_END(4'd0), .COUNT(cnt_b), .TERMINAL(term_b),
        .CARRY_OUT(carry_b), .WINDOW(win_b)
    );

    typedef struct packed {
        logic [9:0] cnt;
        logic       term;
        logic [1:0] win;
    } exp_t;

    typedef struct packed {
        logic [9:0] cnt;
        logic [9:0] mx;
    } ms_t;

    exp_t q[$];
    ms_t  m, ma, mb;
    int   n_pass  = 0;
    int   n_total = 0;
    int   w0_hi, w1_hi, term_hi, carries;

    function automatic ms_t step(ms_t s, logic e, logic c, logic [9:0] mv);
        ms_t r = s;
        if (c) begin
            r.cnt = '0;
            r.mx  = mv;
        end else if (e) begin
            if (s.cnt == s.mx) begin
                r.cnt = '0;
                r.mx  = mv;
            end else begin
                r.cnt = s.cnt + 10'd1;
            end
        end
        return r;
    endfunction

    function automatic logic in_win(logic [9:0] n, logic [9:0] s, logic [9:0] e);
        if (s <= e) return (n >= s) && (n <= e);
        return (n >= s) || (n <= e);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    // One clock of the main counter: drive, check carry, predict, check outputs.
    task automatic cyc(input logic e, input logic c);
        ms_t  nm;
        exp_t ex, got;
        @(negedge clk);
        en  = e;
        clr = c;
        #1;
        chk("carry_out", carry, {31'd0, (m.cnt == m.mx) && e && !c});
        if (carry) carries++;
        nm      = step(m, e, c, maxv);
        ex.cnt  = nm.cnt;
        ex.term = (nm.cnt == nm.mx);
        ex.win  = {in_win(nm.cnt, cs[19:10], ce[19:10]), in_win(nm.cnt, cs[9:0], ce[9:0])};
        q.push_back(ex);
        m = nm;
        @(posedge clk);
        #1;
        got = q.pop_front();
        chk("count", count, got.cnt);
        chk("terminal", term, got.term);
        chk("window", win, got.win);
        if (win[0]) w0_hi++;
        if (win[1]) w1_hi++;
        if (term)   term_hi++;
    endtask

    // One clock of the cascade pair with the upstream stage enabled.
    task automatic ccyc(input logic c, output logic cb);
        logic ca_exp, cb_exp;
        @(negedge clk);
        en_a  = 1'b1;
        clr_c = c;
        #1;
        ca_exp = (ma.cnt == ma.mx) && !c;
        cb_exp = (mb.cnt == mb.mx) && ca_exp && !c;
        chk("carry_up", carry_a, {31'd0, ca_exp});
        chk("carry_down", carry_b, {31'd0, cb_exp});
        cb = carry_b;
        ma = step(ma, 1'b1, c, 10'd3);
        mb = step(mb, ca_exp, c, 10'd2);
        @(posedge clk);
        #1;
        chk("count_up", cnt_a, ma.cnt);
        chk("count_down", cnt_b, mb.cnt);
    endtask

    initial begin
        logic cb;
        int   first_b, last_b, nb_carry, gap_ok;
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; maxv = 10'd799;
        cs = '0; ce = '0; en_a = 1'b0; clr_c = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", count, 799);
        chk("reset_terminal", term, 1);
        chk("reset_window", win, 0);
        chk("reset_up", cnt_a, 3);
        chk("reset_down", cnt_b, 2);

        cs = {10'd700, 10'd656};
        ce = {10'd10, 10'd751};
        @(negedge clk);
        rst_n = 1'b1;
        m = '{cnt: 10'd799, mx: 10'd799};

        // full period from reset: 799, 0 .. 799
        w0_hi = 0; w1_hi = 0; term_hi = 0; carries = 0;
        repeat (800) cyc(1'b1, 1'b0);
        chk("win0_cycles", w0_hi, 96);
        chk("win1_cycles", w1_hi, 111);
        chk("terminal_cycles", term_hi, 1);
        chk("carries_per_period", carries, 1);
        chk("period_end", count, 799);
        cyc(1'b1, 1'b0);

        // MAX_VALUE change mid-period takes effect at the following wrap
        repeat (300) cyc(1'b1, 1'b0);
        maxv = 10'd524;
        repeat (499) cyc(1'b1, 1'b0);
        chk("old_max_hold", count, 799);
        chk("old_max_term", term, 1);
        cyc(1'b1, 1'b0);
        chk("wrap_after_799", count, 0);
        repeat (524) cyc(1'b1, 1'b0);
        chk("new_max_count", count, 524);
        chk("new_max_term", term, 1);

        // ENABLE toggling: terminal persists across the stall at max
        maxv = 10'd799;
        term_hi = 0; carries = 0;
        for (int i = 0; i < 1602; i++) cyc(i[0], 1'b0);
        chk("toggle_term_cycles", term_hi, 3);
        chk("toggle_carries", carries, 2);

        // CLEAR at 400, then CLEAR coinciding with a wrap
        while (m.cnt != 10'd400) cyc(1'b1, 1'b0);
        carries = 0;
        cyc(1'b1, 1'b1);
        chk("clear_count", count, 0);
        while (m.cnt != m.mx) cyc(1'b1, 1'b0);
        carries = 0;
        cyc(1'b1, 1'b1);
        chk("clear_at_max_carry", carries, 0);
        chk("clear_at_max_count", count, 0);

        // MAX_VALUE = 0: stuck at 0, terminal high, carry follows ENABLE
        maxv = 10'd0;
        cyc(1'b1, 1'b1);
        carries = 0;
        repeat (4) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        chk("zero_max_carries", carries, 4);
        chk("zero_max_term", term, 1);

        // window bounds change while stalled
        maxv = 10'd799;
        cyc(1'b1, 1'b1);
        cs[9:0] = 10'd0;
        ce[9:0] = 10'd0;
        cyc(1'b0, 1'b0);
        chk("window_change_stalled", win[0], 1);
        cs[9:0] = 10'd656;
        ce[9:0] = 10'd751;

        // asynchronous reset mid-cycle at count 123
        while (m.cnt != 10'd123) cyc(1'b1, 1'b0);
        chk("pre_reset_count", count, 123);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_count", count, 799);
        chk("async_reset_term", term, 1);
        chk("async_reset_window", win, 0);
        m  = '{cnt: 10'd799, mx: 10'd799};
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cyc(1'b1, 1'b0);
        en = 1'b0;

        // cascade: upstream MAX 3, downstream MAX 2
        ma = '{cnt: 10'd3, mx: 10'd3};
        mb = '{cnt: 10'd2, mx: 10'd2};
        ccyc(1'b1, cb);
        first_b = -1; last_b = -1; nb_carry = 0; gap_ok = 1;
        for (int i = 0; i < 48; i++) begin
            ccyc(1'b0, cb);
            if (cb) begin
                if (last_b >= 0 && (i - last_b) != 12) gap_ok = 0;
                if (first_b < 0) first_b = i;
                last_b = i;
                nb_carry++;
            end
        end
        chk("cascade_carries", nb_carry, 4);
        chk("cascade_spacing", gap_ok, 1);
        chk("cascade_first", first_b, 11);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
